// File: rtl/nr_sync_pkg.sv
// Shared NR synchronisation-signal constants: sequence length, cell-ID range,
// N_id_1/N_id_2 widths, LFSR init vectors and taps, generator FSM state codes
// and the PSS offset helper. Imported by the transmit generator and the
// receive-side PSS/SSS detectors.
package nr_sync_pkg;

  localparam int unsigned PSS_LEN  = 127;
  localparam int unsigned N_ID_MAX = 1007;
  localparam int unsigned NID_W    = 10;
  localparam int unsigned NID1_W   = 9;
  localparam int unsigned NID2_W   = 2;

  // Bit k of an init vector is x(k).
  localparam logic [6:0] PSS_INIT  = 7'b1110110;
  localparam logic [6:0] SSS0_INIT = 7'b0000001;
  localparam logic [6:0] SSS1_INIT = 7'b0000001;

  // Feedback x(i+7) = x(i+TAP) ^ x(i).
  localparam int unsigned PSS_TAP  = 4;
  localparam int unsigned SSS0_TAP = 4;
  localparam int unsigned SSS1_TAP = 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DIV     = 3'd1;
  localparam logic [2:0] ST_OFFS    = 3'd2;
  localparam logic [2:0] ST_PREROLL = 3'd3;
  localparam logic [2:0] ST_PSS     = 3'd4;
  localparam logic [2:0] ST_SSS     = 3'd5;

  // (43 * N_id_2) mod 127 for N_id_2 in 0..2.
  function automatic logic [6:0] pss_offset(input logic [NID2_W-1:0] nid2);
    logic [6:0] m;
    case (nid2)
      2'd0:    m = 7'd0;
      2'd1:    m = 7'd43;
      default: m = 7'd86;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ssb_seq_tx_if.sv
// AXI-stream bundle for the sync-sequence generator output.
//   tdata  : {imag, real}, each OUT_DW/2 signed
//   tuser  : 0 = PSS sample, 1 = SSS sample
//   tlast  : last sample of each 127-sample sequence
//   tvalid / tready : handshake
interface ssb_seq_tx_if #(
  parameter int unsigned OUT_DW = 32
) ();

  logic [OUT_DW-1:0] tdata;
  logic              tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/nr_lfsr7.sv
// 7-bit Fibonacci LFSR, x(i+7) = x(i+Tap) ^ x(i).
//   clk, rst_n : clock, async active-low reset (state returns to Init)
//   load       : reload Init (takes priority over advance)
//   advance    : step the sequence by one
//   out_bit    : current x(i)
module nr_lfsr7 #(
  parameter int unsigned Tap  = 4,
  parameter logic [6:0]  Init = 7'b0000001
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic advance,
  output logic out_bit
);

  // s_q[k] holds x(i+k).
  logic [6:0] s_q, s_d;

  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = Init;
    end else if (advance) begin
      s_d = {s_q[Tap] ^ s_q[0], s_q[6:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= Init;
    end else begin
      s_q <= s_d;
    end
  end

  assign out_bit = s_q[0];

endmodule

// File: rtl/ssb_seq_tx.sv
// NR PSS/SSS transmit generator. For a cell ID it streams the 127-sample BPSK
// PSS followed by the 127-sample SSS.
//   clk_i, reset_ni : clock, async active-low reset
//   N_id_i, start_i : cell ID and request (honoured only when idle)
//   busy_o          : high whenever not idle
//   err_o           : one-cycle pulse on a start with N_id_i > 1007
//   m_axis_out      : AXI-stream master, real = +/-AMP, imag = 0
module ssb_seq_tx
  import nr_sync_pkg::*;
#(
  parameter int unsigned OUT_DW = 32,
  parameter int          AMP    = 8192
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [NID_W-1:0] N_id_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             err_o,
  ssb_seq_tx_if.master     m_axis_out
);

  localparam int unsigned      HalfW   = OUT_DW / 2;
  localparam logic [HalfW-1:0] AmpPos  = HalfW'(AMP);
  localparam logic [HalfW-1:0] AmpNeg  = HalfW'(-AMP);
  localparam logic [6:0]       LastIdx = 7'(PSS_LEN - 1);

  logic [2:0] state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [9:0] quo_q, quo_d;  // dividend shifts out as quotient shifts in
  logic [1:0] rem_q, rem_d;
  logic [6:0] mp_q, mp_d, m0_q, m0_d, m1_q, m1_d;
  logic       err_q, err_d;

  logic              hs, last_beat, in_seq, load;
  logic              adv_p, adv_0, adv_1, bit_p, bit_0, bit_1, neg;
  logic [2:0]        div_t;
  logic              div_ge;
  logic [NID1_W-1:0] nid1;
  logic [1:0]        nid1_hi;  // N_id_1 / 112

  assign hs        = m_axis_out.tvalid & m_axis_out.tready;
  assign last_beat = (cnt_q == LastIdx);
  assign div_t     = {rem_q, quo_q[9]};
  assign div_ge    = (div_t >= 3'd3);
  assign nid1      = quo_q[NID1_W-1:0];
  assign nid1_hi   = (nid1 >= 9'd224) ? 2'd2 : (nid1 >= 9'd112) ? 2'd1 : 2'd0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    mp_d    = mp_q;
    m0_d    = m0_q;
    m1_d    = m1_q;
    err_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (N_id_i > 10'(N_ID_MAX)) begin
            err_d = 1'b1;
          end else begin
            quo_d   = N_id_i;
            rem_d   = 2'd0;
            cnt_d   = 7'd0;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        // Restoring divide by 3, MSB first.
        quo_d = {quo_q[8:0], div_ge};
        rem_d = div_ge ? 2'(div_t - 3'd3) : div_t[1:0];
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd9) begin
          cnt_d   = 7'd0;
          state_d = ST_OFFS;
        end
      end
      ST_OFFS: begin
        mp_d    = pss_offset(rem_q);
        m0_d    = 7'(nid1_hi) * 7'd15 + 7'(rem_q) * 7'd5;
        m1_d    = 7'(nid1 - 9'(nid1_hi) * 9'd112);
        load    = 1'b1;
        cnt_d   = 7'd0;
        state_d = ST_PREROLL;
      end
      ST_PREROLL: begin
        cnt_d = cnt_q + 7'd1;
        if (last_beat) begin
          cnt_d   = 7'd0;
          state_d = ST_PSS;
        end
      end
      ST_PSS, ST_SSS: begin
        if (hs) begin
          cnt_d = cnt_q + 7'd1;
          if (last_beat) begin
            cnt_d   = 7'd0;
            state_d = (state_q == ST_PSS) ? ST_SSS : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      mp_q    <= '0;
      m0_q    <= '0;
      m1_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      mp_q    <= mp_d;
      m0_q    <= m0_d;
      m1_q    <= m1_d;
      err_q   <= err_d;
    end
  end

  // Preroll steps each LFSR to its own offset; afterwards they step on handshakes.
  assign adv_p = ((state_q == ST_PREROLL) && (cnt_q < mp_q)) || ((state_q == ST_PSS) && hs);
  assign adv_0 = ((state_q == ST_PREROLL) && (cnt_q < m0_q)) || ((state_q == ST_SSS) && hs);
  assign adv_1 = ((state_q == ST_PREROLL) && (cnt_q < m1_q)) || ((state_q == ST_SSS) && hs);

  nr_lfsr7 #(.Tap(PSS_TAP), .Init(PSS_INIT)) u_lfsr_pss (
    .clk(clk_i), .rst_n(reset_ni), .load(load), .advance(adv_p), .out_bit(bit_p)
  );

  nr_lfsr7 #(.Tap(SSS0_TAP), .Init(SSS0_INIT)) u_lfsr_sss0 (
    .clk(clk_i), .rst_n(reset_ni), .load(load), .advance(adv_0), .out_bit(bit_0)
  );

  nr_lfsr7 #(.Tap(SSS1_TAP), .Init(SSS1_INIT)) u_lfsr_sss1 (
    .clk(clk_i), .rst_n(reset_ni), .load(load), .advance(adv_1), .out_bit(bit_1)
  );

  assign in_seq = (state_q == ST_PSS) || (state_q == ST_SSS);
  assign neg    = (state_q == ST_SSS) ? (bit_0 ^ bit_1) : bit_p;

  assign m_axis_out.tvalid = in_seq;
  assign m_axis_out.tuser  = (state_q == ST_SSS);
  assign m_axis_out.tlast  = in_seq && last_beat;
  assign m_axis_out.tdata  = in_seq ? {{HalfW{1'b0}}, (neg ? AmpNeg : AmpPos)} : '0;

  assign busy_o = (state_q != ST_IDLE);
  assign err_o  = err_q;

endmodule

// File: tb/tb_ssb_seq_tx.sv
// Directed bench for ssb_seq_tx: reset values, latency, golden-model sequence
// compare, random backpressure, error/ignore paths and mid-sequence reset.
module tb_ssb_seq_tx;

  logic       clk_i;
  logic       reset_ni;
  logic       start_i;
  logic [9:0] N_id_i;
  logic       busy_o;
  logic       err_o;

  ssb_seq_tx_if #(.OUT_DW(32)) axis ();

  ssb_seq_tx #(.OUT_DW(32), .AMP(8192)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .N_id_i     (N_id_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .m_axis_out (axis)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          n_chk;
  int          n_pass;
  bit          xs[127];
  bit          x0s[127];
  bit          x1s[127];
  logic [33:0] got[254];
  int          n_got;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] samp(input bit b);
    return b ? 32'h0000E000 : 32'h00002000;
  endfunction

  // Golden {tlast, tuser, tdata} for beat i (0..253) of cell nid.
  function automatic logic [33:0] expected(input int nid, input int i);
    int nid1, nid2, mp, m0, m1, n;
    bit b;
    nid1 = nid / 3;
    nid2 = nid % 3;
    mp   = (43 * nid2) % 127;
    m0   = 15 * (nid1 / 112) + 5 * nid2;
    m1   = nid1 % 112;
    if (i < 127) begin
      b = xs[(i + mp) % 127];
      return {(i == 126), 1'b0, samp(b)};
    end
    n = i - 127;
    b = x0s[(n + m0) % 127] ^ x1s[(n + m1) % 127];
    return {(n == 126), 1'b1, samp(b)};
  endfunction

  task automatic do_start(input int nid);
    N_id_i  = 10'(nid);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_first(input string tag);
    int lat;
    lat = 1;
    while (!axis.tvalid && lat < 400) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check(tag, 64'(lat), 64'(139));
  endtask

  task automatic collect(input bit rnd, input int poke, input int abort, output bit aborted);
    int          steps;
    bit          prev_stall, last_stalled;
    logic [33:0] cur, held;
    n_got = 0; steps = 0; prev_stall = 0; last_stalled = 0; aborted = 0; held = '0;
    while (n_got < 254 && steps < 2000) begin
      cur = {axis.tlast, axis.tuser, axis.tdata};
      check("tvalid_held", 64'(axis.tvalid), 64'(1));
      if (prev_stall) check("stall_stable", 64'(cur), 64'(held));
      if (n_got == abort) begin
        aborted = 1;
        break;
      end
      axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd && axis.tlast && !last_stalled) begin
        axis.tready  = 1'b0;
        last_stalled = 1;
      end
      if (n_got == poke) begin
        start_i = 1'b1;
        N_id_i  = 10'd7;
      end else begin
        start_i = 1'b0;
      end
      if (axis.tvalid && axis.tready) begin
        got[n_got]   = cur;
        n_got++;
        last_stalled = 0;
      end
      prev_stall = axis.tvalid && !axis.tready;
      held       = cur;
      @(posedge clk_i); #1;
      steps++;
    end
    start_i = 1'b0;
    if (!aborted) begin
      check("beat_count", 64'(n_got), 64'(254));
      if (!rnd) check("throughput", 64'(steps), 64'(254));
    end
  endtask

  task automatic compare_all(input int nid, input string tag);
    for (int i = 0; i < 254; i++) begin
      check($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(expected(nid, i)));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_tvalid"}, 64'(axis.tvalid), 64'(0));
    check({tag, "_tdata"}, 64'(axis.tdata), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ab;
    logic [6:0]  pss_init;
    logic [6:0]  pss0_neg;

    n_chk = 0;
    n_pass = 0;
    pss_init = 7'b1110110;
    for (int k = 0; k < 7; k++) begin
      xs[k]  = pss_init[k];
      x0s[k] = (k == 0);
      x1s[k] = (k == 0);
    end
    for (int i = 0; i < 120; i++) begin
      xs[i+7]  = xs[i+4] ^ xs[i];
      x0s[i+7] = x0s[i+4] ^ x0s[i];
      x1s[i+7] = x1s[i+1] ^ x1s[i];
    end

    // Reset values
    reset_ni = 1'b0; start_i = 1'b0; N_id_i = '0; axis.tready = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_idle("reset");
    check("reset_err", 64'(err_o), 64'(0));
    check("reset_tlast", 64'(axis.tlast), 64'(0));
    check("reset_tuser", 64'(axis.tuser), 64'(0));
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    // N_id = 0, tready held high
    do_start(0);
    check("busy_rise", 64'(busy_o), 64'(1));
    wait_first("latency_nid0");
    collect(1'b0, -1, -1, ab);
    compare_all(0, "nid0");
    pss0_neg = 7'b1110110;  // +A,-A,-A,+A,-A,-A,-A
    for (int i = 0; i < 7; i++) begin
      check($sformatf("nid0_pss_hand%0d", i), 64'(got[i][31:0]),
            64'(pss0_neg[i] ? 32'h0000E000 : 32'h00002000));
    end
    for (int i = 0; i < 9; i++) begin
      check($sformatf("nid0_sss_hand%0d", i), 64'(got[127+i][31:0]), 64'(32'h00002000));
    end
    check("tlast_beat127", 64'(got[126][33]), 64'(1));
    check("tlast_beat254", 64'(got[253][33]), 64'(1));
    check("tuser_beat127", 64'(got[126][32]), 64'(0));
    check("tuser_beat128", 64'(got[127][32]), 64'(1));
    check_idle("done_nid0");

    // N_id = 1007 with random backpressure, stalls on tlast beats
    do_start(1007);
    wait_first("latency_nid1007");
    collect(1'b1, -1, -1, ab);
    compare_all(1007, "nid1007");
    check_idle("done_nid1007");

    // Out-of-range start
    do_start(1008);
    check("err_pulse", 64'(err_o), 64'(1));
    check("err_busy", 64'(busy_o), 64'(0));
    @(posedge clk_i); #1;
    check("err_clear", 64'(err_o), 64'(0));
    repeat (150) @(posedge clk_i);
    #1;
    check_idle("err_no_output");

    // Start during PSS is ignored
    do_start(5);
    wait_first("latency_nid5");
    collect(1'b0, 20, -1, ab);
    compare_all(5, "nid5_poke");
    check_idle("done_nid5");

    // Restart in the first idle cycle, then reset at PSS beat 50
    do_start(0);
    wait_first("latency_restart");
    collect(1'b0, -1, 50, ab);
    check("aborted", 64'(ab), 64'(1));
    reset_ni = 1'b0;
    #2;
    check_idle("async_reset");
    check("async_reset_tlast", 64'(axis.tlast), 64'(0));
    check("async_reset_tuser", 64'(axis.tuser), 64'(0));
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    repeat (200) @(posedge clk_i);
    #1;
    check_idle("no_resume");
    do_start(0);
    wait_first("latency_after_reset");
    collect(1'b0, -1, -1, ab);
    compare_all(0, "nid0_again");

    // N_id_1 = 112 boundary (m0 = 15, m1 = 0) with backpressure
    do_start(336);
    wait_first("latency_nid336");
    collect(1'b1, -1, -1, ab);
    compare_all(336, "nid336");
    check_idle("done_nid336");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ssb_seq_tx.md
# ssb_seq_tx

Transmit-side generator for the NR synchronisation signals. Given a physical cell ID N_id, it produces the 127-sample BPSK frequency-domain PSS sequence and then the 127-sample SSS sequence as an AXI-stream. This is the inverse of the receive-side PSS/SSS detection chain. It feeds the subcarrier mapper/IFFT of the SSB transmit path, and the bench uses it as the stimulus source for loopback tests of the receive chain.

## Interface
Parameters:
- OUT_DW, 32, output sample width; packed {imag, real}, each OUT_DW/2 signed.
- AMP, 8192, BPSK magnitude written to the real part; must fit OUT_DW/2 signed.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- N_id_i  in  10  cell ID, 0..1007; sampled together with start_i.
- start_i  in  1  request generation; honoured only in IDLE.
- busy_o  out  1  high in every state other than IDLE.
- err_o  out  1  one-cycle pulse when start_i is rejected because N_id_i > 1007.
- m_axis_out_tdata  out  OUT_DW  sample; real = ±AMP, imag = 0.
- m_axis_out_tuser  out  1  0 = PSS sample, 1 = SSS sample.
- m_axis_out_tlast  out  1  high on sample 126 of each sequence.
- m_axis_out_tvalid  out  1  AXI-stream valid.
- m_axis_out_tready  in  1  AXI-stream ready.

## Operation
- States: IDLE, DIV, OFFS, PREROLL, PSS, SSS.
- **IDLE**
  - start_i=1 with N_id_i ≤ 1007: latch N_id_i, go to DIV.
  - start_i=1 with N_id_i > 1007: pulse err_o, stay in IDLE.
- **DIV** (exactly 10 cycles): restoring divide by 3, one quotient bit per cycle.
  - N_id_1 = N_id / 3 (9 bits).
  - N_id_2 = N_id mod 3 (2 bits).
- **OFFS** (1 cycle): compute the offsets and load the LFSRs.
  - m_p = (43·N_id_2) mod 127.
  - m0 = 15·(N_id_1 / 112) + 5·N_id_2.
  - m1 = N_id_1 mod 112.
  - PSS LFSR: recurrence x(i+7) = x(i+4) ⊕ x(i); init x(0..6) = 0,1,1,0,1,1,1.
  - SSS LFSR0: same recurrence as PSS; init x0(0)=1, rest 0.
  - SSS LFSR1: recurrence x1(i+7) = x1(i+1) ⊕ x1(i); init x1(0)=1, rest 0.
- **PREROLL** (exactly 127 cycles, counter c = 0..126):
  - Each LFSR advances one step while c < its own offset (m_p, m0 or m1).
  - At the end, each LFSR's output bit equals x(m).
- **PSS**: 127 beats.
  - Sample n = x((n+m_p) mod 127); bit 0 → +AMP, bit 1 → −AMP.
  - The PSS LFSR advances only on a handshake (tvalid & tready).
  - Modulo-127 wrap is implicit because the m-sequence period is 127.
  - tuser = 0; tlast on n = 126, then go to SSS with no bubble.
- **SSS**: 127 beats.
  - Sample = x0((n+m0) mod 127) ⊕ x1((n+m1) mod 127), mapped the same way (0 → +AMP, 1 → −AMP).
  - tuser = 1; tlast on n = 126; after the last handshake go to IDLE.
- Handshake rules:
  - tdata, tuser and tlast are stable while tvalid & !tready.
  - tvalid never drops mid-sequence.
- start_i while busy is ignored; no error is raised.

## Timing
- Reset values:
  - state = IDLE.
  - busy_o, err_o, tvalid, tlast, tuser = 0.
  - tdata = 0.
  - LFSRs hold their init values.
- Reset asserted mid-operation aborts immediately. Outputs return to reset values asynchronously; no partial sequence resumes afterwards.
- Latency: start_i sampled at edge k.
  - DIV occupies k+1..k+10.
  - OFFS occupies k+11.
  - PREROLL occupies k+12..k+138.
  - First tvalid = 1 at k+139, independent of N_id.
- busy_o rises at k+1 and falls the cycle after the final SSS handshake.
- err_o is registered: a rejected start at edge k produces a pulse during k+1 only.
- Throughput with tready held high: 254 consecutive beats. Total start-to-IDLE = 139 + 254 cycles.
- Next start is accepted the cycle busy_o = 0.

## Structure
- Shared package nr_sync_pkg, holding:
  - PSS_LEN = 127 and N_id_MAX = 1007.
  - N_id_1 / N_id_2 widths.
  - LFSR init vectors and tap positions.
  - The state enum.
- The receive-side SSS/PSS detectors import the same package constants.
- One sub-module, nr_lfsr7:
  - 7-bit Fibonacci LFSR, parameterised by tap and init.
  - Ports: load, advance, output bit.
  - Instantiated three times (PSS, SSS x0, SSS x1).
- The divide-by-3 stays inline in the top FSM.

## Test plan
- **N_id=0, tready=1**: first tvalid 139 cycles after start.
  - PSS samples 0..6 = +A,−A,−A,+A,−A,−A,−A (A = 8192).
  - SSS samples 0..8 all +A.
  - tlast on beats 127 and 254; tuser switches at beat 128.
- **N_id=1007**: DIV yields N_id_1=335, N_id_2=2; offsets m_p=86, m0=40, m1=111.
  - All 254 samples match the bit-exact golden model of 38.211 §7.4.2.
- **Sweep all 1008 N_id**: every sequence matches the golden model.
  - Loopback into the receive-side SSS detector returns the same N_id.
- **Random tready** (50% duty, including stalls on tlast beats): no sample dropped or duplicated, tdata stable while stalled.
- **Error and ignore paths**:
  - start with N_id_i=1008: err_o pulses for 1 cycle, busy_o stays 0, no output.
  - start_i asserted during PSS: ignored, sequence unaffected.
- **Reset mid-operation**: assert reset_ni low at PSS beat 50.
  - Outputs go to 0 immediately.
  - A fresh start with N_id=0 reproduces the same sequence as the first test.
